// File: rtl/mem_port_arbiter.sv
// Three-master arbiter for the single-port instruction/data memory.
// Handles a debug loader, core load/store and fetch, with bus locking and starvation boost.
module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2:0]      m_req,
  input  logic [2:0]      m_we,
  input  logic [2:0]      m_lock,
  input  logic [3*AW-1:0] m_addr,
  input  logic [95:0]     m_wdata,
  input  logic [11:0]     m_wstrb,
  output logic [2:0]      m_gnt,
  output logic [2:0]      m_rvalid,
  output logic [31:0]     m_rdata,
  output logic            mem_en,
  output logic [3:0]      mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic [31:0]     mem_rdata
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);
  localparam logic [1:0] NONE = 2'd3;

  typedef enum logic {ARB, LOCKED} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic          rr_q, rr_d;          // 0 = m1 next, 1 = m2 next
  logic          rd_pend_q, rd_pend_d;
  logic [1:0]    rd_id_q, rd_id_d;
  logic [31:0]   rdata_q;
  logic [CW-1:0] starve1_q, starve1_d, starve2_q, starve2_d;
  logic [2:0]    gnt_c;
  logic [1:0]    gid;
  logic          boost1, boost2;

  // Winner selection and next-state
  always_comb begin
    gnt_c     = 3'b000;
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    gid       = 2'd0;
    boost1    = m_req[1] && (starve1_q == SMAX);
    boost2    = m_req[2] && (starve2_q == SMAX);
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;

    case (state_q)
      ARB: begin
        if (boost1)                 gnt_c = 3'b010;
        else if (boost2)            gnt_c = 3'b100;
        else if (m_req[0])          gnt_c = 3'b001;
        else if (!rr_q && m_req[1]) gnt_c = 3'b010;
        else if (m_req[2])          gnt_c = 3'b100;
        else if (m_req[1])          gnt_c = 3'b010;
        if (|(gnt_c & m_lock)) begin
          state_d = LOCKED;
          owner_d = gnt_c[0] ? 2'd0 : (gnt_c[1] ? 2'd1 : 2'd2);
        end
      end
      LOCKED: begin
        case (owner_q)
          2'd0:    gnt_c = {2'b00, m_req[0]};
          2'd1:    gnt_c = {1'b0, m_req[1], 1'b0};
          2'd2:    gnt_c = {m_req[2], 2'b00};
          default: gnt_c = 3'b000;
        endcase
        // Release on an unlocked owner access or when the owner goes idle
        if (!(|gnt_c) || !(|(gnt_c & m_lock))) begin
          state_d = ARB;
          owner_d = NONE;
        end
      end
      default: begin
        state_d = ARB;
        owner_d = NONE;
      end
    endcase

    if (gnt_c[1]) gid = 2'd1;
    if (gnt_c[2]) gid = 2'd2;
    if (gnt_c[1]) rr_d = 1'b1;
    if (gnt_c[2]) rr_d = 1'b0;

    if (|(gnt_c & ~m_we)) begin
      rd_pend_d = 1'b1;
      rd_id_d   = gid;
    end

    starve1_d = (!m_req[1] || gnt_c[1]) ? '0 : ((starve1_q == SMAX) ? SMAX : starve1_q + CW'(1));
    starve2_d = (!m_req[2] || gnt_c[2]) ? '0 : ((starve2_q == SMAX) ? SMAX : starve2_q + CW'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ARB;
      owner_q   <= NONE;
      rr_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 2'd0;
      rdata_q   <= '0;
      starve1_q <= '0;
      starve2_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
      rdata_q   <= m_rdata;
      starve1_q <= starve1_d;
      starve2_q <= starve2_d;
    end
  end

  // Outputs are forced low while reset is asserted
  assign m_gnt     = rst ? gnt_c : 3'b000;
  assign mem_en    = |m_gnt;
  assign mem_addr  = mem_en ? m_addr[gid*AW +: AW] : '0;
  assign mem_wdata = mem_en ? m_wdata[gid*32 +: 32] : '0;
  assign mem_we    = mem_en ? (m_wstrb[gid*4 +: 4] & {4{m_we[gid]}}) : 4'b0000;
  assign m_rvalid  = rd_pend_q ? (3'b001 << rd_id_q) : 3'b000;
  assign m_rdata   = rd_pend_q ? mem_rdata : rdata_q;

endmodule
